// File: rtl/outpkt_config.sv
// Serialises a latched config value as SUBTYPE byte + little-endian data bytes (+ XOR byte with OUTPKT_CONFIG_CSUM_EN).
// Latency: subtype byte one cycle after start, then one byte per cycle; full stalls in place, wr_en = busy & !full.
module outpkt_config #(
    parameter int SUBTYPE1_WIDTH = -1,
    parameter int SUBTYPE        = 1
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      start,
    input  logic [SUBTYPE1_WIDTH-1:0] din1,
    output logic                      busy,
    output logic [7:0]                dout,
    output logic                      wr_en,
    output logic                      pkt_end,
    input  logic                      full
);

    // A non-positive width is not meaningful; clamp so the block still elaborates.
    localparam int W  = (SUBTYPE1_WIDTH > 0) ? SUBTYPE1_WIDTH : 1;
    localparam int NB = (W + 7) / 8;
    localparam int CW = $clog2(NB + 1);
    localparam logic [CW-1:0] LAST  = CW'(NB - 1);
    localparam logic [7:0]    SUB_B = 8'(SUBTYPE);

`ifdef OUTPKT_CONFIG_CSUM_EN
    typedef enum logic [1:0] {S_IDLE, S_SUBTYPE, S_DATA, S_CSUM} state_t;
    logic [7:0] csum_r;
`else
    typedef enum logic [1:0] {S_IDLE, S_SUBTYPE, S_DATA} state_t;
`endif

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [NB-1:0][7:0]  data_r;
    logic [NB-1:0][7:0]  din_ext;
    logic [7:0]          cur_byte;
    logic                xfer;
    logic                last_byte;

    // Zero-pad the unused top bits of the last data byte.
    always_comb begin
        din_ext = '0;
        for (int i = 0; i < W; i++) din_ext[i / 8][i % 8] = din1[i];
    end

    always_comb begin
        cur_byte = '0;
        for (int k = 0; k < NB; k++)
            if (cnt == CW'(k)) cur_byte = data_r[k];
    end

    assign xfer = (state != S_IDLE) && !full;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= S_IDLE;
            cnt    <= '0;
            data_r <= '0;
`ifdef OUTPKT_CONFIG_CSUM_EN
            csum_r <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    data_r <= din_ext;
                    cnt    <= '0;
`ifdef OUTPKT_CONFIG_CSUM_EN
                    csum_r <= '0;
`endif
                    state  <= S_SUBTYPE;
                end
                S_SUBTYPE: if (!full) state <= S_DATA;
                S_DATA: if (!full) begin
                    cnt <= cnt + CW'(1);
`ifdef OUTPKT_CONFIG_CSUM_EN
                    csum_r <= csum_r ^ cur_byte;
                    if (cnt == LAST) state <= S_CSUM;
`else
                    if (cnt == LAST) state <= S_IDLE;
`endif
                end
`ifdef OUTPKT_CONFIG_CSUM_EN
                S_CSUM: if (!full) state <= S_IDLE;
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        dout      = '0;
        last_byte = 1'b0;
        case (state)
            S_SUBTYPE: dout = SUB_B;
            S_DATA: begin
                dout = cur_byte;
`ifndef OUTPKT_CONFIG_CSUM_EN
                last_byte = (cnt == LAST);
`endif
            end
`ifdef OUTPKT_CONFIG_CSUM_EN
            S_CSUM: begin
                dout      = csum_r;
                last_byte = 1'b1;
            end
`endif
            default: dout = '0;
        endcase
    end

    assign busy    = (state != S_IDLE);
    assign wr_en   = xfer;
    assign pkt_end = xfer && last_byte;

endmodule

// File: tb/tb_outpkt_config.sv
// Scoreboard bench for outpkt_config at widths 16 and 12; follows OUTPKT_CONFIG_CSUM_EN when defined.
module tb_outpkt_config;

`ifdef OUTPKT_CONFIG_CSUM_EN
    localparam int BYTES_AFTER_SUB = 3;
`else
    localparam int BYTES_AFTER_SUB = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start16 = 1'b0, start12 = 1'b0;
    logic [15:0] din16 = '0;
    logic [11:0] din12 = '0;
    logic        full16 = 1'b0, full12 = 1'b0;
    logic        busy16, busy12, wr_en16, wr_en12, pkt_end16, pkt_end12;
    logic [7:0]  dout16, dout12;

    logic [8:0]  q16[$];
    logic [8:0]  q12[$];
    logic [8:0]  e16, e12;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    outpkt_config #(.SUBTYPE1_WIDTH(16), .SUBTYPE(1)) dut16 (
        .CLK(clk), .RST_N(rst_n), .start(start16), .din1(din16), .busy(busy16),
        .dout(dout16), .wr_en(wr_en16), .pkt_end(pkt_end16), .full(full16)
    );

    outpkt_config #(.SUBTYPE1_WIDTH(12), .SUBTYPE(1)) dut12 (
        .CLK(clk), .RST_N(rst_n), .start(start12), .din1(din12), .busy(busy12),
        .dout(dout12), .wr_en(wr_en12), .pkt_end(pkt_end12), .full(full12)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // Expected byte stream: {pkt_end, byte}.
    task automatic push_pkt(input bit is12, input logic [15:0] v);
        logic [7:0] b0, b1;
        logic [8:0] ents[4];
        int         n;
        b0 = v[7:0];
        b1 = is12 ? {4'h0, v[11:8]} : v[15:8];
        ents[0] = {1'b0, 8'h01};
        ents[1] = {1'b0, b0};
`ifdef OUTPKT_CONFIG_CSUM_EN
        ents[2] = {1'b0, b1};
        ents[3] = {1'b1, b0 ^ b1};
        n = 4;
`else
        ents[2] = {1'b1, b1};
        ents[3] = '0;
        n = 3;
`endif
        for (int i = 0; i < n; i++) begin
            if (is12) q12.push_back(ents[i]);
            else      q16.push_back(ents[i]);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en16) begin
            if (q16.size() == 0) chk("extra16", 1, 0);
            else begin
                e16 = q16.pop_front();
                chk("byte16", {23'd0, pkt_end16, dout16}, {23'd0, e16});
            end
        end
        if (pkt_end16 && !wr_en16) chk("pe_no_we16", 1, 0);
        if (wr_en12) begin
            if (q12.size() == 0) chk("extra12", 1, 0);
            else begin
                e12 = q12.pop_front();
                chk("byte12", {23'd0, pkt_end12, dout12}, {23'd0, e12});
            end
        end
        if (pkt_end12 && !wr_en12) chk("pe_no_we12", 1, 0);
    end

    task automatic drain(input bit is12);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (is12 ? (q12.size() == 0 && !busy12) : (q16.size() == 0 && !busy16)) break;
        end
        chk(is12 ? "drain12" : "drain16", is12 ? q12.size() : q16.size(), 0);
        chk(is12 ? "idle_dout12" : "idle_dout16", is12 ? dout12 : dout16, 0);
    endtask

    // Start pulse, then check subtype latency and cycles to pkt_end.
    task automatic send(input bit is12, input logic [15:0] v);
        int n;
        push_pkt(is12, v);
        @(negedge clk);
        if (is12) begin start12 = 1'b1; din12 = v[11:0]; end
        else      begin start16 = 1'b1; din16 = v; end
        @(posedge clk); #1;
        start12 = 1'b0; start16 = 1'b0;
        @(negedge clk);
        chk("lat_sub", is12 ? wr_en12 : wr_en16, 1);
        chk("busy_on", is12 ? busy12 : busy16, 1);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n++;
            if (is12 ? pkt_end12 : pkt_end16) break;
        end
        chk("lat_end", n, BYTES_AFTER_SUB);
        drain(is12);
    endtask

    initial begin
        #1;
        chk("rst_busy", busy16, 0);
        chk("rst_we", wr_en16, 0);
        chk("rst_dout", dout16, 0);
        chk("rst_pe", pkt_end16, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        send(1'b0, 16'hA55A);
        send(1'b1, 16'h0ABC);
        send(1'b0, 16'h3C96);

        // Back-pressure while the first data byte is pending.
        push_pkt(1'b0, 16'hA55A);
        @(negedge clk); start16 = 1'b1; din16 = 16'hA55A;
        @(posedge clk); #1; start16 = 1'b0;
        @(posedge clk); #1; full16 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_we", wr_en16, 0);
            chk("stall_dout", dout16, 8'h5A);
        end
        @(posedge clk); #1; full16 = 1'b0;
        drain(1'b0);

        // Re-start attempts mid-packet and on the pkt_end cycle are ignored.
        push_pkt(1'b0, 16'h8001);
        @(negedge clk); start16 = 1'b1; din16 = 16'h8001;
        @(posedge clk); #1; din16 = 16'h1234;
        @(posedge clk); #1; start16 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pkt_end16) begin
                start16 = 1'b1;
                @(posedge clk); #1; start16 = 1'b0;
                break;
            end
        end
        repeat (8) @(negedge clk);
        chk("no_restart", busy16, 0);
        chk("restart_q", q16.size(), 0);

        // Asynchronous reset after the subtype byte abandons the packet.
        push_pkt(1'b0, 16'hA55A);
        @(negedge clk); start16 = 1'b1; din16 = 16'hA55A;
        @(posedge clk); #1; start16 = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_busy", busy16, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_we", wr_en16, 0);
        chk("arst_busy", busy16, 0);
        chk("arst_pe", pkt_end16, 0);
        chk("arst_dout", dout16, 0);
        q16.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_idle", busy16, 0);
        send(1'b0, 16'h00FF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/outpkt_config.md
OUTPKT_CONFIG -- requirements
Module: outpkt_config

Interface
REQ-001 SHALL have parameter SUBTYPE1_WIDTH, default -1 (must be overridden), bit width of the config value to transmit.
REQ-002 SHALL have parameter SUBTYPE, default 1, value of the subtype byte sent first in each packet.
REQ-003 SHALL have port CLK  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request to send one config packet.
REQ-006 SHALL have port din1  input  SUBTYPE1_WIDTH  value captured when start is accepted.
REQ-007 SHALL have port busy  output  1  high from the cycle after start is accepted until the last byte is accepted.
REQ-008 SHALL have port dout  output  8  current output byte.
REQ-009 SHALL have port wr_en  output  1  byte on dout is written this cycle.
REQ-010 SHALL have port pkt_end  output  1  high with wr_en on the last byte of the packet.
REQ-011 SHALL have port full  input  1  downstream cannot accept a byte this cycle.

Function
REQ-012 N_BYTES SHALL equal ceil(SUBTYPE1_WIDTH/8); the counter is just wide enough to hold N_BYTES.
REQ-013 The packet SHALL consist of one SUBTYPE byte, then N_BYTES data bytes, little-endian: data byte k = value[8k+7:8k], with unused top bits of the last byte zero-padded.
REQ-014 FSM states SHALL be IDLE, SUBTYPE, DATA and (with the REQ-026 option) CSUM; reset state is IDLE.
REQ-015 IDLE: start=1 latches din1 into an internal register, clears the byte counter and moves to SUBTYPE on the same edge; start=0 keeps the state in IDLE.
REQ-016 wr_en SHALL be combinational: (state != IDLE) and !full; a byte transfers on each edge where wr_en=1.
REQ-017 dout SHALL be SUBTYPE in state SUBTYPE, latched byte[cnt] in state DATA, and 0 in state IDLE.
REQ-018 SUBTYPE with a transfer SHALL move to DATA.
REQ-019 DATA with a transfer SHALL increment cnt; the transfer at cnt = N_BYTES-1 is the last byte and SHALL return to IDLE (or go to CSUM with the option).
REQ-020 pkt_end SHALL equal wr_en AND final byte of the packet; pkt_end SHALL never be high while wr_en is low.
REQ-021 full=1 SHALL stall: state, cnt and dout hold, and wr_en=0.
REQ-022 Latency: with full=0, the subtype byte transfers 1 cycle after start, and the last byte transfers N_BYTES cycles after the subtype byte (N_BYTES+1 with the option).
REQ-023 start outside IDLE SHALL be ignored, including on the cycle the last byte transfers; din1 changes while busy SHALL NOT affect the packet.
REQ-024 busy SHALL be (state != IDLE).

Reset
REQ-025 RST_N=0 SHALL immediately, without waiting for CLK, force state IDLE, cnt 0, the latched value 0 and the checksum 0; busy, wr_en and pkt_end SHALL go 0 and dout SHALL go 0. A packet interrupted this way SHALL be abandoned and not resumed; the first start after reset release SHALL send a complete new packet.

Configuration
REQ-026 Macro OUTPKT_CONFIG_CSUM_EN:
- Defined: after the last data byte, state CSUM SHALL send one extra byte equal to the XOR of all N_BYTES data bytes.
- Defined: pkt_end SHALL be asserted on that checksum byte instead of on the last data byte.
- Defined: the checksum register SHALL clear when start is accepted.
- Undefined: no CSUM state and no checksum logic; the packet is SUBTYPE plus N_BYTES data bytes.

Verification
REQ-027 W=16, din1=16'hA55A, start pulse, full=0 -> bytes 01,5A,A5 on 3 consecutive cycles, pkt_end on A5. With CSUM_EN: 01,5A,A5,FF, with pkt_end on FF.
REQ-028 W=12, din1=12'hABC -> bytes 01,BC,0A, pkt_end on 0A (the top nibble is zero-padded).
REQ-029 W=16, full=1 for 3 cycles while the first data byte is pending -> wr_en=0 and dout=5A held for those cycles, then 5A,A5 transfer; no byte is duplicated or lost.
REQ-030 start re-pulsed with din1=16'h1234 mid-packet, and again on the pkt_end cycle -> the current packet is unchanged and no second packet is sent.
REQ-031 RST_N low after the subtype byte -> wr_en, busy and pkt_end drop at once. After release, start with 16'h00FF -> complete packet 01,FF,00.
